// File: rtl/csr_file_pkg.sv
// Shared core definitions for the machine-mode CSR file: widths, CSR
// addresses, trap cause codes and register field positions.
package csr_file_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int CSR_ADDRW = 12;

  localparam logic [CSR_ADDRW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDRW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_ADDRW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDRW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDRW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDRW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDRW-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_ADDRW-1:0] CSR_MCYCLE   = 12'hB00;

  localparam logic [CPU_WIDTH-1:0] MCAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [CPU_WIDTH-1:0] MCAUSE_ECALL_M = 64'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  // Control-flow event resolved for the current cycle, already prioritised.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_INTR  = 2'd1,
    EV_ECALL = 2'd2,
    EV_MRET  = 2'd3
  } trap_ev_e;

endpackage

// File: rtl/csr_file_if.sv
// Bus between the core pipeline (master) and the CSR file (slave):
// decode read port, writeback write/retire info, interrupt and redirect.
interface csr_file_if;
  import csr_file_pkg::*;

  logic [CSR_ADDRW-1:0] i_csr_rid;
  logic [CPU_WIDTH-1:0] o_csr_rdata;

  logic [CSR_ADDRW-1:0] i_wbu_csrdid;
  logic                 i_wbu_csrdwen;
  logic [CPU_WIDTH-1:0] i_wbu_csrd;

  logic                 i_wbu_commit;
  logic [CPU_WIDTH-1:0] i_wbu_pc;
  logic                 i_wbu_ecall;
  logic                 i_wbu_mret;

  logic                 i_mtip;
  logic                 i_intr_take;
  logic [CPU_WIDTH-1:0] i_intr_pc;
  logic                 o_intr_pending;

  logic                 o_flush;
  logic [CPU_WIDTH-1:0] o_flush_pc;

  modport master (
    output i_csr_rid, i_wbu_csrdid, i_wbu_csrdwen, i_wbu_csrd,
           i_wbu_commit, i_wbu_pc, i_wbu_ecall, i_wbu_mret,
           i_mtip, i_intr_take, i_intr_pc,
    input  o_csr_rdata, o_intr_pending, o_flush, o_flush_pc
  );

  modport slave (
    input  i_csr_rid, i_wbu_csrdid, i_wbu_csrdwen, i_wbu_csrd,
           i_wbu_commit, i_wbu_pc, i_wbu_ecall, i_wbu_mret,
           i_mtip, i_intr_take, i_intr_pc,
    output o_csr_rdata, o_intr_pending, o_flush, o_flush_pc
  );

endinterface

// File: rtl/csr_file_stl_reg.sv
// Generic enabled register with asynchronous active-low reset to a
// parameterised value; the only storage primitive used by the CSR file.
module stl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: masked CSR writes, free-running mcycle, timer
// interrupt request, and trap entry/return with a one-cycle redirect.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_MTVEC = 64'h0
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  csr_file_if.slave bus
);

  trap_ev_e             ev;
  logic                 is_event;
  logic                 is_trap;
  logic                 csr_we;
  logic [CPU_WIDTH-1:0] wdata;

  logic we_mstatus, we_mie, we_mtvec, we_mscratch;
  logic we_mepc, we_mcause, we_mcycle;

  logic                 mstatus_mie_q, mstatus_mie_d;
  logic                 mstatus_mpie_q, mstatus_mpie_d;
  logic                 mie_mtie_q;
  logic [CPU_WIDTH-1:0] mtvec_q, mtvec_d;
  logic [CPU_WIDTH-1:0] mscratch_q;
  logic [CPU_WIDTH-1:0] mepc_q, mepc_d;
  logic [CPU_WIDTH-1:0] mcause_q, mcause_d;
  logic [CPU_WIDTH-1:0] mcycle_q, mcycle_d;
  logic                 flush_q;
  logic [CPU_WIDTH-1:0] flush_pc_q, flush_pc_d;
  logic [CPU_WIDTH-1:0] rdata;

  assign wdata = bus.i_wbu_csrd;

  // Interrupt beats ecall beats mret; ecall/mret only count on a retiring instruction.
  always_comb begin
    ev = EV_NONE;
    if (bus.i_intr_take) begin
      ev = EV_INTR;
    end else if (bus.i_wbu_commit && bus.i_wbu_ecall) begin
      ev = EV_ECALL;
    end else if (bus.i_wbu_commit && bus.i_wbu_mret) begin
      ev = EV_MRET;
    end
  end

  assign is_event = (ev != EV_NONE);
  assign is_trap  = (ev == EV_INTR) || (ev == EV_ECALL);
  assign csr_we   = bus.i_wbu_csrdwen && !is_event;

  assign we_mstatus  = csr_we && (bus.i_wbu_csrdid == CSR_MSTATUS);
  assign we_mie      = csr_we && (bus.i_wbu_csrdid == CSR_MIE);
  assign we_mtvec    = csr_we && (bus.i_wbu_csrdid == CSR_MTVEC);
  assign we_mscratch = csr_we && (bus.i_wbu_csrdid == CSR_MSCRATCH);
  assign we_mepc     = csr_we && (bus.i_wbu_csrdid == CSR_MEPC);
  assign we_mcause   = csr_we && (bus.i_wbu_csrdid == CSR_MCAUSE);
  assign we_mcycle   = csr_we && (bus.i_wbu_csrdid == CSR_MCYCLE);

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    if (is_trap) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (ev == EV_MRET) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (we_mstatus) begin
      mstatus_mie_d  = wdata[MSTATUS_MIE_BIT];
      mstatus_mpie_d = wdata[MSTATUS_MPIE_BIT];
    end
  end

  assign mtvec_d  = {wdata[CPU_WIDTH-1:2], 2'b00};
  assign mepc_d   = (ev == EV_INTR)  ? bus.i_intr_pc :
                    (ev == EV_ECALL) ? bus.i_wbu_pc  :
                                       {wdata[CPU_WIDTH-1:2], 2'b00};
  assign mcause_d = (ev == EV_INTR)  ? MCAUSE_MTI     :
                    (ev == EV_ECALL) ? MCAUSE_ECALL_M :
                                       wdata;
  // A software write to mcycle replaces that cycle's increment.
  assign mcycle_d = we_mcycle ? wdata : (mcycle_q + CPU_WIDTH'(1));
  // mret returns to the mepc held before this edge; traps go to mtvec.
  assign flush_pc_d = (ev == EV_MRET) ? mepc_q : mtvec_q;

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_mstatus_mie (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1),
    .i_d(mstatus_mie_d), .o_q(mstatus_mie_q)
  );

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_mstatus_mpie (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1),
    .i_d(mstatus_mpie_d), .o_q(mstatus_mpie_q)
  );

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_mie_mtie (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(we_mie),
    .i_d(wdata[MIE_MTIE_BIT]), .o_q(mie_mtie_q)
  );

  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL(RESET_MTVEC)) u_mtvec (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(we_mtvec),
    .i_d(mtvec_d), .o_q(mtvec_q)
  );

  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_mscratch (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(we_mscratch),
    .i_d(wdata), .o_q(mscratch_q)
  );

  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_mepc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(is_trap || we_mepc),
    .i_d(mepc_d), .o_q(mepc_q)
  );

  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_mcause (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(is_trap || we_mcause),
    .i_d(mcause_d), .o_q(mcause_q)
  );

  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_mcycle (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1),
    .i_d(mcycle_d), .o_q(mcycle_q)
  );

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_flush (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(1'b1),
    .i_d(is_event), .o_q(flush_q)
  );

  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_flush_pc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(is_event),
    .i_d(flush_pc_d), .o_q(flush_pc_q)
  );

  always_comb begin
    rdata = '0;
    case (bus.i_csr_rid)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        rdata[MSTATUS_MPIE_BIT]              = mstatus_mpie_q;
        rdata[MSTATUS_MIE_BIT]               = mstatus_mie_q;
      end
      CSR_MIE:      rdata[MIE_MTIE_BIT] = mie_mtie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MIP:      rdata[MIP_MTIP_BIT] = bus.i_mtip;
      CSR_MCYCLE:   rdata = mcycle_q;
      default:      rdata = '0;
    endcase
  end

  assign bus.o_csr_rdata    = rdata;
  assign bus.o_intr_pending = mstatus_mie_q & mie_mtie_q & bus.i_mtip;
  assign bus.o_flush        = flush_q;
  assign bus.o_flush_pc     = flush_pc_q;

endmodule
